// File: rtl/cache_types_pkg.sv
// Shared cache geometry constants and address helpers used by the cache
// and its memory-side adaptor.
package cache_types_pkg;

    localparam int DEF_BURST_W  = 64;
    localparam int DEF_BEATS    = 4;
    localparam int DEF_LINE_W   = DEF_BURST_W * DEF_BEATS;
    localparam int CACHE_LINE_W = 256;
    localparam int LINE_OFFS_W  = 5;

    // Strip the byte offset so the address names the whole 32-byte line.
    function automatic logic [31:0] line_align(input logic [31:0] addr);
        return {addr[31:LINE_OFFS_W], {LINE_OFFS_W{1'b0}}};
    endfunction

endpackage

// File: rtl/cacheline_adaptor_if.sv
// Bundle of the cache-side (pmem_*) and memory-side (mem_*) buses around the
// line adaptor. slave is the adaptor's view, master is the environment's.
interface cacheline_adaptor_if
    import cache_types_pkg::*;
#(
    parameter int BURST_W = DEF_BURST_W,
    parameter int BEATS   = DEF_BEATS
);
    localparam int LINE_W = BURST_W * BEATS;

    logic [31:0]        pmem_address;
    logic [LINE_W-1:0]  pmem_wdata;
    logic               pmem_read;
    logic               pmem_write;
    logic [LINE_W-1:0]  pmem_rdata;
    logic               pmem_resp;

    logic [31:0]        mem_address;
    logic               mem_read;
    logic               mem_write;
    logic [BURST_W-1:0] mem_wdata;
    logic [BURST_W-1:0] mem_rdata;
    logic               mem_resp;

    modport slave (
        input  pmem_address, pmem_wdata, pmem_read, pmem_write, mem_rdata, mem_resp,
        output pmem_rdata, pmem_resp, mem_address, mem_read, mem_write, mem_wdata
    );

    modport master (
        output pmem_address, pmem_wdata, pmem_read, pmem_write, mem_rdata, mem_resp,
        input  pmem_rdata, pmem_resp, mem_address, mem_read, mem_write, mem_wdata
    );

endinterface

// File: rtl/cacheline_adaptor.sv
// Splits a cache line fill / write-back into BEATS memory bursts of BURST_W
// bits and reassembles read beats into a full line.
module cacheline_adaptor
    import cache_types_pkg::*;
#(
    parameter int BURST_W = DEF_BURST_W,
    parameter int BEATS   = DEF_BEATS
)(
    input  logic                clk,
    input  logic                rst,
    cacheline_adaptor_if.slave  bus
);

    localparam int LINE_W = BURST_W * BEATS;
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        addr_q, addr_d;
    logic [LINE_W-1:0]  wline_q, wline_d;
    logic [LINE_W-1:0]  rline_q, rline_d;

    logic               mem_read;
    logic               mem_write;
    logic               pmem_resp;
    logic [BURST_W-1:0] mem_wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wline_q <= '0;
            rline_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wline_q <= wline_d;
            rline_q <= rline_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wline_d   = wline_q;
        rline_d   = rline_q;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        pmem_resp = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Write-back takes priority so a dirty victim leaves before the fill.
                if (bus.pmem_write || bus.pmem_read) begin
                    state_d = bus.pmem_write ? S_WRITE : S_READ;
                    addr_d  = line_align(bus.pmem_address);
                    wline_d = bus.pmem_wdata;
                    cnt_d   = '0;
                end
            end

            S_READ: begin
                mem_read = 1'b1;
                if (bus.mem_resp) begin
                    for (int b = 0; b < BEATS; b++) begin
                        if (cnt_q == CNT_W'(b)) begin
                            rline_d[b*BURST_W +: BURST_W] = bus.mem_rdata;
                        end
                    end
                    if (cnt_q == LAST_BEAT) state_d = S_DONE;
                    else                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end

            S_WRITE: begin
                mem_write = 1'b1;
                if (bus.mem_resp) begin
                    if (cnt_q == LAST_BEAT) state_d = S_DONE;
                    else                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end

            S_DONE: begin
                // Back to IDLE regardless, so a still-held request is not replayed.
                pmem_resp = 1'b1;
                state_d   = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mem_wdata = '0;
        for (int b = 0; b < BEATS; b++) begin
            if (cnt_q == CNT_W'(b)) begin
                mem_wdata = wline_q[b*BURST_W +: BURST_W];
            end
        end
    end

    assign bus.mem_read    = mem_read;
    assign bus.mem_write   = mem_write;
    assign bus.mem_wdata   = mem_wdata;
    assign bus.mem_address = addr_q;
    assign bus.pmem_resp   = pmem_resp;
    assign bus.pmem_rdata  = rline_q;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed bench for cacheline_adaptor: fills, write-backs, arbitration,
// held requests, asynchronous reset and stray memory responses.
module tb_cacheline_adaptor;

    localparam int BW = 64;
    localparam int NB = 4;
    localparam int LW = BW * NB;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   resp_cnt;

    cacheline_adaptor_if #(.BURST_W(BW), .BEATS(NB)) bus ();

    cacheline_adaptor #(.BURST_W(BW), .BEATS(NB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (bus.pmem_resp === 1'b1) resp_cnt++;

    logic [BW-1:0] rb [NB];
    logic [BW-1:0] wd [NB];
    logic [LW-1:0] fill_line;

    task automatic test_reset();
        rst = 1'b1;
        bus.pmem_address = '0; bus.pmem_wdata = '0;
        bus.pmem_read = 1'b0;  bus.pmem_write = 1'b0;
        bus.mem_rdata = '0;    bus.mem_resp = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if ({bus.mem_read, bus.mem_write, bus.pmem_resp} !== 3'b000) begin
            errors++; $display("FAIL reset_ctrl got %b want 000", {bus.mem_read, bus.mem_write, bus.pmem_resp}); end
        checks++; if (bus.mem_address !== 32'h0) begin
            errors++; $display("FAIL reset_addr got %h want 0", bus.mem_address); end
        checks++; if (bus.pmem_rdata !== '0 || bus.mem_wdata !== '0) begin
            errors++; $display("FAIL reset_data rdata %h wdata %h want 0", bus.pmem_rdata, bus.mem_wdata); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_read_fill();
        rb[0] = {16{4'h1}}; rb[1] = {16{4'h2}}; rb[2] = {16{4'h3}}; rb[3] = {16{4'h4}};
        fill_line = {rb[3], rb[2], rb[1], rb[0]};
        bus.pmem_address = 32'h0000_1234; bus.pmem_read = 1'b1;
        @(negedge clk);
        checks++; if (bus.mem_read !== 1'b1 || bus.mem_write !== 1'b0) begin
            errors++; $display("FAIL read_req got rd %b wr %b want 1 0", bus.mem_read, bus.mem_write); end
        checks++; if (bus.mem_address !== 32'h0000_1220) begin
            errors++; $display("FAIL read_addr got %h want 00001220", bus.mem_address); end
        for (int i = 0; i < NB; i++) begin
            bus.mem_resp = 1'b1; bus.mem_rdata = rb[i];
            @(negedge clk);
            if (i < NB - 1) begin
                checks++; if (bus.pmem_resp !== 1'b0) begin
                    errors++; $display("FAIL read_early_resp beat %0d got %b want 0", i, bus.pmem_resp); end
            end
        end
        bus.mem_resp = 1'b0; bus.pmem_read = 1'b0;
        checks++; if (bus.pmem_resp !== 1'b1 || bus.mem_read !== 1'b0) begin
            errors++; $display("FAIL read_done got resp %b rd %b want 1 0", bus.pmem_resp, bus.mem_read); end
        checks++; if (bus.pmem_rdata !== fill_line) begin
            errors++; $display("FAIL read_line got %h want %h", bus.pmem_rdata, fill_line); end
        @(negedge clk);
        checks++; if (bus.pmem_resp !== 1'b0) begin
            errors++; $display("FAIL read_resp_width got %b want 0", bus.pmem_resp); end
        checks++; if (bus.pmem_rdata !== fill_line) begin
            errors++; $display("FAIL read_hold got %h want %h", bus.pmem_rdata, fill_line); end
    endtask

    task automatic test_held_request();
        int r0;
        r0 = resp_cnt;
        rb[0] = {16{4'h5}}; rb[1] = {16{4'h6}}; rb[2] = {16{4'h7}}; rb[3] = {16{4'h8}};
        fill_line = {rb[3], rb[2], rb[1], rb[0]};
        bus.pmem_address = 32'h0000_0040; bus.pmem_read = 1'b1;
        @(negedge clk);
        for (int i = 0; i < NB; i++) begin
            bus.mem_resp = 1'b1; bus.mem_rdata = rb[i];
            @(negedge clk);
        end
        bus.mem_resp = 1'b0;
        checks++; if (bus.pmem_resp !== 1'b1) begin
            errors++; $display("FAIL held_done got %b want 1", bus.pmem_resp); end
        @(negedge clk);
        bus.pmem_read = 1'b0;
        checks++; if (bus.mem_read !== 1'b0 || bus.pmem_resp !== 1'b0) begin
            errors++; $display("FAIL held_restart got rd %b resp %b want 0 0", bus.mem_read, bus.pmem_resp); end
        @(negedge clk);
        checks++; if (resp_cnt - r0 !== 1 || bus.mem_read !== 1'b0) begin
            errors++; $display("FAIL held_once got %0d resps rd %b want 1 0", resp_cnt - r0, bus.mem_read); end
        checks++; if (bus.pmem_rdata !== fill_line) begin
            errors++; $display("FAIL held_line got %h want %h", bus.pmem_rdata, fill_line); end
    endtask

    task automatic test_write_back();
        logic [5:0] pat;
        int k, r0;
        pat = 6'b101101;
        r0 = resp_cnt;
        wd[0] = {8{8'hD0}}; wd[1] = {8{8'hD1}}; wd[2] = {8{8'hD2}}; wd[3] = {8{8'hD3}};
        bus.pmem_wdata = {wd[3], wd[2], wd[1], wd[0]};
        bus.pmem_address = 32'hABCD_EF7F; bus.pmem_write = 1'b1;
        @(negedge clk);
        // Scramble the cache side; only the registered copies may matter now.
        bus.pmem_wdata = '1; bus.pmem_address = 32'h0;
        checks++; if (bus.mem_address !== 32'hABCD_EF60) begin
            errors++; $display("FAIL wb_addr got %h want abcdef60", bus.mem_address); end
        k = 0;
        for (int j = 0; j < 6; j++) begin
            checks++; if (bus.mem_write !== 1'b1 || bus.mem_read !== 1'b0 || bus.mem_wdata !== wd[k]) begin
                errors++; $display("FAIL wb_beat cyc %0d got wr %b rd %b data %h want 1 0 %h",
                                   j, bus.mem_write, bus.mem_read, bus.mem_wdata, wd[k]); end
            bus.mem_resp = pat[j];
            @(negedge clk);
            if (pat[j]) k++;
        end
        bus.mem_resp = 1'b0; bus.pmem_write = 1'b0;
        checks++; if (bus.pmem_resp !== 1'b1 || bus.mem_write !== 1'b0) begin
            errors++; $display("FAIL wb_done got resp %b wr %b want 1 0", bus.pmem_resp, bus.mem_write); end
        checks++; if (bus.mem_address !== 32'hABCD_EF60) begin
            errors++; $display("FAIL wb_addr_held got %h want abcdef60", bus.mem_address); end
        @(negedge clk);
        checks++; if (resp_cnt - r0 !== 1 || bus.pmem_resp !== 1'b0) begin
            errors++; $display("FAIL wb_once got %0d resps resp %b want 1 0", resp_cnt - r0, bus.pmem_resp); end
        checks++; if (bus.pmem_rdata !== fill_line) begin
            errors++; $display("FAIL wb_rline_kept got %h want %h", bus.pmem_rdata, fill_line); end
    endtask

    task automatic test_simultaneous();
        wd[0] = {8{8'hE0}}; wd[1] = {8{8'hE1}}; wd[2] = {8{8'hE2}}; wd[3] = {8{8'hE3}};
        bus.pmem_wdata = {wd[3], wd[2], wd[1], wd[0]};
        bus.pmem_address = 32'h0000_0100; bus.pmem_read = 1'b1; bus.pmem_write = 1'b1;
        @(negedge clk);
        for (int i = 0; i < NB; i++) begin
            checks++; if (bus.mem_write !== 1'b1 || bus.mem_read !== 1'b0 || bus.mem_wdata !== wd[i]) begin
                errors++; $display("FAIL both_beat %0d got wr %b rd %b data %h want 1 0 %h",
                                   i, bus.mem_write, bus.mem_read, bus.mem_wdata, wd[i]); end
            bus.mem_resp = 1'b1;
            @(negedge clk);
        end
        bus.mem_resp = 1'b0; bus.pmem_read = 1'b0; bus.pmem_write = 1'b0;
        checks++; if (bus.pmem_resp !== 1'b1) begin
            errors++; $display("FAIL both_done got %b want 1", bus.pmem_resp); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_burst();
        bus.pmem_address = 32'h0000_2000; bus.pmem_read = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            bus.mem_resp = 1'b1; bus.mem_rdata = {16{4'h9}};
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        checks++; if ({bus.mem_read, bus.mem_write, bus.pmem_resp} !== 3'b000) begin
            errors++; $display("FAIL mid_rst_ctrl got %b want 000", {bus.mem_read, bus.mem_write, bus.pmem_resp}); end
        checks++; if (bus.mem_address !== 32'h0 || bus.mem_wdata !== '0 || bus.pmem_rdata !== '0) begin
            errors++; $display("FAIL mid_rst_data addr %h wdata %h rdata %h want 0",
                               bus.mem_address, bus.mem_wdata, bus.pmem_rdata); end
        bus.pmem_read = 1'b0; bus.mem_resp = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rb[0] = {16{4'hA}}; rb[1] = {16{4'hB}}; rb[2] = {16{4'hC}}; rb[3] = {16{4'hD}};
        fill_line = {rb[3], rb[2], rb[1], rb[0]};
        bus.pmem_address = 32'h0000_3000; bus.pmem_read = 1'b1;
        @(negedge clk);
        checks++; if (bus.mem_read !== 1'b1 || bus.mem_address !== 32'h0000_3000) begin
            errors++; $display("FAIL post_rst_req got rd %b addr %h want 1 00003000", bus.mem_read, bus.mem_address); end
        for (int i = 0; i < NB; i++) begin
            bus.mem_resp = 1'b1; bus.mem_rdata = rb[i];
            @(negedge clk);
        end
        bus.mem_resp = 1'b0; bus.pmem_read = 1'b0;
        checks++; if (bus.pmem_resp !== 1'b1 || bus.pmem_rdata !== fill_line) begin
            errors++; $display("FAIL post_rst_fill got resp %b line %h want 1 %h", bus.pmem_resp, bus.pmem_rdata, fill_line); end
        @(negedge clk);
    endtask

    task automatic test_stray_resp();
        int r0;
        r0 = resp_cnt;
        bus.mem_rdata = {16{4'hF}};
        for (int i = 0; i < 3; i++) begin
            bus.mem_resp = 1'b1;
            @(negedge clk);
            checks++; if ({bus.mem_read, bus.mem_write, bus.pmem_resp} !== 3'b000) begin
                errors++; $display("FAIL stray_ctrl cyc %0d got %b want 000", i, {bus.mem_read, bus.mem_write, bus.pmem_resp}); end
        end
        bus.mem_resp = 1'b0;
        @(negedge clk);
        checks++; if (resp_cnt != r0 || bus.pmem_rdata !== fill_line) begin
            errors++; $display("FAIL stray_effect got %0d resps line %h want 0 %h", resp_cnt - r0, bus.pmem_rdata, fill_line); end
    endtask

    initial begin
        checks = 0; errors = 0; resp_cnt = 0;
        test_reset();
        test_read_fill();
        test_held_request();
        test_write_back();
        test_simultaneous();
        test_reset_mid_burst();
        test_stray_resp();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cacheline_adaptor.md
CACHELINE_ADAPTOR -- requirements
Module: cacheline_adaptor

Interface
REQ-001 The block SHALL have one clock and one reset; the reset is asynchronous and active-high.
REQ-002 Parameter BURST_W, default 64: width of one memory beat in bits.
REQ-003 Parameter BEATS, default 4: number of beats per cache line.
REQ-004 The line width SHALL be LINE_W = BURST_W*BEATS, which is 256 at the defaults.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 pmem_address  in  32  line address from the cache.
REQ-008 pmem_wdata  in  LINE_W  dirty line to write back.
REQ-009 pmem_read  in  1  line-fill request; held until pmem_resp.
REQ-010 pmem_write  in  1  write-back request; held until pmem_resp.
REQ-011 pmem_rdata  out  LINE_W  assembled fill line.
REQ-012 pmem_resp  out  1  one-cycle completion pulse.
REQ-013 mem_address  out  32  burst address; bits [4:0] SHALL be forced to 0.
REQ-014 mem_read  out  1  burst read request.
REQ-015 mem_write  out  1  burst write request.
REQ-016 mem_wdata  out  BURST_W  current write beat.
REQ-017 mem_rdata  in  BURST_W  incoming read beat.
REQ-018 mem_resp  in  1  beat accepted or valid; one beat per high cycle, gaps allowed.

Function
REQ-019 States SHALL be: IDLE, READ, WRITE, DONE.
REQ-020 IDLE transitions:
- pmem_write=1 -> WRITE (write wins if both are high).
- else pmem_read=1 -> READ.
- else stay in IDLE.
REQ-021 On leaving IDLE, the block SHALL register pmem_address (low 5 bits zeroed), register pmem_wdata, and clear the beat counter.
REQ-022 READ behaviour:
- mem_read=1 every cycle.
- Each cycle with mem_resp=1, mem_rdata SHALL be stored into line slice [counter*BURST_W +: BURST_W] and the counter incremented.
- The cycle the beat with counter=BEATS-1 is captured -> DONE.
REQ-023 WRITE behaviour:
- mem_write=1 every cycle.
- mem_wdata = slice [counter] of the registered line.
- Each cycle with mem_resp=1 increments the counter.
- mem_resp=1 with counter=BEATS-1 -> DONE.
REQ-024 DONE behaviour:
- pmem_resp=1 for exactly one cycle; mem_read=mem_write=0.
- pmem_rdata holds the full assembled line.
- Next state is unconditionally IDLE, so a request still held in that cycle is not restarted.
REQ-025 pmem_rdata SHALL keep the last filled line until the next READ overwrites it beat by beat.
REQ-026 mem_resp outside READ or WRITE SHALL be ignored.
REQ-027 Latency after the final beat's mem_resp cycle is 1 cycle to pmem_resp. Minimum transaction is 1 (IDLE) + BEATS + 1 (DONE) cycles.
REQ-028 The counter SHALL be $clog2(BEATS) bits wide and SHALL never wrap within a transaction.
REQ-029 Changes to pmem_* inputs mid-transaction SHALL have no effect, since only the registered copies are used.

Reset
REQ-030 Asserting rst at any time, including mid-burst, SHALL immediately give:
- state IDLE, counter 0;
- mem_read=mem_write=pmem_resp=0;
- mem_address=0, mem_wdata=0, pmem_rdata=0.
REQ-031 After rst deasserts, the first request SHALL be sampled on the next rising edge in IDLE.

Structure
REQ-032 BURST_W, BEATS and LINE_W defaults SHALL live in shared package cache_types_pkg, alongside the cache's line-width constant. The state enum stays local.
REQ-033 The block SHALL contain no sub-module: one FSM, one counter and two line registers.

Verification
REQ-034 Read fill: pmem_read=1, addr 0x0000_1234, memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 on consecutive mem_resp.
- mem_address=0x0000_1220.
- pmem_rdata = {0x44..,0x33..,0x22..,0x11..}.
- pmem_resp pulses exactly 1 cycle after the 4th beat.
REQ-035 Write-back: pmem_wdata = {D3,D2,D1,D0}, mem_resp pattern 1,0,1,1,0,1.
- mem_wdata steps D0, D1, D2, D3, advancing only on resp.
- pmem_resp occurs once, the cycle after the final resp.
REQ-036 Simultaneous request: pmem_read=pmem_write=1 -> WRITE burst is performed and mem_read stays 0.
REQ-037 Held request: pmem_read is held high through the DONE cycle and dropped afterwards -> exactly one burst and one pmem_resp.
REQ-038 Reset mid-operation: rst asserted after beat 2 of a read -> all outputs go 0 asynchronously. A following fresh read then completes normally with correct data.
REQ-039 Stray response: mem_resp pulsed while IDLE -> no state change and no pmem_resp.
